// File: rtl/uart_cmd_parser.sv
// ----------------------------------------------------------------------------
// uart_cmd_parser
//
// Sits behind a UART receiver. It assembles frames of the form
//   SYNC, CMD, LEN, payload[LEN], CHK
// and checks each one for length, XOR checksum and inter-byte timeout. A good
// frame is held for the command executor behind a valid/ack handshake. Its
// payload stays in a local buffer that the executor reads through a
// combinational port.
//
// Handshake: o_Cmd_Valid rises on the edge that samples a correct checksum
// byte. It stays high, with o_Cmd/o_Len stable, until an edge samples
// i_Cmd_Ack. That edge also returns the parser to idle. i_Cmd_Ack has no
// effect while no command is pending.
//
// Parameters
//   MAX_LEN       maximum payload length and buffer depth (1..255)
//   SYNC_BYTE     frame start marker
//   TIMEOUT_CLKS  idle clocks allowed between bytes inside a frame
//
// Ports
//   i_Clock       system clock
//   i_Reset       asynchronous, active-high reset
//   i_Rx_DV       one-cycle strobe, i_Rx_Byte valid
//   i_Rx_Byte     received byte
//   i_Cmd_Ack     executor consumed the pending command
//   i_Rd_Addr     payload buffer read address
//   o_Cmd_Valid   command pending (registered)
//   o_Cmd         command byte of the pending frame (registered)
//   o_Len         payload length of the pending frame (registered)
//   o_Rd_Data     buf[i_Rd_Addr], 0 when out of range (combinational)
//   o_Err         one-cycle frame-error pulse (registered)
//   o_Err_Code    last error cause: 01 length, 10 checksum, 11 timeout
//   o_Overrun     one-cycle pulse, byte dropped while a command is pending
//   o_Dbg_State   current FSM state, for observation only
// ----------------------------------------------------------------------------
module uart_cmd_parser #(
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hAA,
  parameter int         TIMEOUT_CLKS = 4340
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  input  logic       i_Cmd_Ack,
  input  logic [7:0] i_Rd_Addr,
  output logic       o_Cmd_Valid,
  output logic [7:0] o_Cmd,
  output logic [7:0] o_Len,
  output logic [7:0] o_Rd_Data,
  output logic       o_Err,
  output logic [1:0] o_Err_Code,
  output logic       o_Overrun,
  output logic [2:0] o_Dbg_State
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHK     = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  localparam logic [1:0] ERR_LEN = 2'b01;
  localparam logic [1:0] ERR_CHK = 2'b10;
  localparam logic [1:0] ERR_TO  = 2'b11;

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  localparam int             CW      = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CLKS - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    chk_q, chk_d;
  logic [7:0]    idx_q, idx_d;
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          overrun_q, overrun_d;
  logic          buf_we;

  logic [7:0]    pbuf_q [MAX_LEN];

  logic          in_frame;

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    len_d      = len_q;
    chk_d      = chk_q;
    idx_d      = idx_q;
    to_cnt_d   = to_cnt_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    overrun_d  = 1'b0;
    buf_we     = 1'b0;
    in_frame   = 1'b0;

    case (state_q)
      S_IDLE: begin
        to_cnt_d = '0;
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
          state_d = S_CMD;
        end
      end

      S_CMD: begin
        in_frame = 1'b1;
        if (i_Rx_DV) begin
          cmd_d   = i_Rx_Byte;
          chk_d   = i_Rx_Byte;
          state_d = S_LEN;
        end
      end

      S_LEN: begin
        in_frame = 1'b1;
        if (i_Rx_DV) begin
          if (i_Rx_Byte > MAX_LEN_B) begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = S_IDLE;
          end else begin
            len_d   = i_Rx_Byte;
            chk_d   = chk_q ^ i_Rx_Byte;
            idx_d   = 8'd0;
            state_d = (i_Rx_Byte == 8'd0) ? S_CHK : S_PAYLOAD;
          end
        end
      end

      S_PAYLOAD: begin
        in_frame = 1'b1;
        if (i_Rx_DV) begin
          buf_we = 1'b1;
          chk_d  = chk_q ^ i_Rx_Byte;
          idx_d  = idx_q + 8'd1;
          // len_q >= 1 here, so len_q - 1 cannot wrap.
          if (idx_q == (len_q - 8'd1)) begin
            state_d = S_CHK;
          end
        end
      end

      S_CHK: begin
        in_frame = 1'b1;
        if (i_Rx_DV) begin
          if (i_Rx_Byte == chk_q) begin
            state_d = S_HOLD;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CHK;
            state_d    = S_IDLE;
          end
        end
      end

      S_HOLD: begin
        to_cnt_d = '0;
        // Any byte arriving now is lost, including in the ack cycle.
        if (i_Rx_DV) begin
          overrun_d = 1'b1;
        end
        if (i_Cmd_Ack) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d  = S_IDLE;
        to_cnt_d = '0;
      end
    endcase

    // Inter-byte timeout. A byte in the last allowed cycle wins.
    if (in_frame) begin
      if (i_Rx_DV) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TO_LAST) begin
        to_cnt_d   = '0;
        err_d      = 1'b1;
        err_code_d = ERR_TO;
        state_d    = S_IDLE;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end

    // Registered so that o_Cmd_Valid is glitch-free and not a state decode.
    cmd_valid_d = (state_d == S_HOLD);
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q     <= S_IDLE;
      cmd_q       <= 8'd0;
      len_q       <= 8'd0;
      chk_q       <= 8'd0;
      idx_q       <= 8'd0;
      to_cnt_q    <= '0;
      cmd_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      chk_q       <= chk_d;
      idx_q       <= idx_d;
      to_cnt_q    <= to_cnt_d;
      cmd_valid_q <= cmd_valid_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      overrun_q   <= overrun_d;
    end
  end

  // Payload buffer. Only written from S_PAYLOAD; contents survive ack.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        pbuf_q[i] <= 8'd0;
      end
    end else if (buf_we) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (idx_q == 8'(i)) begin
          pbuf_q[i] <= i_Rx_Byte;
        end
      end
    end
  end

  // Combinational read. Addresses at or above MAX_LEN return 0.
  always_comb begin
    o_Rd_Data = 8'd0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i_Rd_Addr == 8'(i)) begin
        o_Rd_Data = pbuf_q[i];
      end
    end
  end

  assign o_Cmd_Valid = cmd_valid_q;
  assign o_Cmd       = cmd_q;
  assign o_Len       = len_q;
  assign o_Err       = err_q;
  assign o_Err_Code  = err_code_q;
  assign o_Overrun   = overrun_q;
  assign o_Dbg_State = state_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// ----------------------------------------------------------------------------
// tb_uart_cmd_parser
//
// Directed bench for uart_cmd_parser. A table of whole frames with
// hand-computed results is applied first. Hand-written sequences then cover
// the timeout edges, overrun, out-of-range reads and asynchronous reset.
// Inputs change 1 ns after the rising edge. Outputs are compared at that
// point or later, never on the edge itself.
// ----------------------------------------------------------------------------
module tb_uart_cmd_parser;

  localparam int MAX_LEN      = 16;
  localparam int TIMEOUT_CLKS = 4340;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CHK  = 3'd4;
  localparam logic [2:0] ST_HOLD = 3'd5;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic       i_Clock   = 1'b0;
  logic       i_Reset   = 1'b1;
  logic       i_Rx_DV   = 1'b0;
  logic [7:0] i_Rx_Byte = 8'h00;
  logic       i_Cmd_Ack = 1'b0;
  logic [7:0] i_Rd_Addr = 8'h00;
  logic       o_Cmd_Valid;
  logic [7:0] o_Cmd;
  logic [7:0] o_Len;
  logic [7:0] o_Rd_Data;
  logic       o_Err;
  logic [1:0] o_Err_Code;
  logic       o_Overrun;
  logic [2:0] o_Dbg_State;

  always #5 i_Clock = ~i_Clock;

  uart_cmd_parser #(
    .MAX_LEN      (MAX_LEN),
    .SYNC_BYTE    (8'hAA),
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) dut (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Rx_DV     (i_Rx_DV),
    .i_Rx_Byte   (i_Rx_Byte),
    .i_Cmd_Ack   (i_Cmd_Ack),
    .i_Rd_Addr   (i_Rd_Addr),
    .o_Cmd_Valid (o_Cmd_Valid),
    .o_Cmd       (o_Cmd),
    .o_Len       (o_Len),
    .o_Rd_Data   (o_Rd_Data),
    .o_Err       (o_Err),
    .o_Err_Code  (o_Err_Code),
    .o_Overrun   (o_Overrun),
    .o_Dbg_State (o_Dbg_State)
  );

  // --------------------------------------------------------------------------
  // Scoreboard counters and pulse monitor
  // --------------------------------------------------------------------------
  int checks     = 0;
  int errors     = 0;
  int err_pulses = 0;
  int ovr_pulses = 0;

  always @(negedge i_Clock) begin
    if (o_Err)     err_pulses++;
    if (o_Overrun) ovr_pulses++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = b;
    tick();
    i_Rx_DV   = 1'b0;
  endtask

  task automatic ack();
    i_Cmd_Ack = 1'b1;
    tick();
    i_Cmd_Ack = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Frame vectors: bytes packed first-byte-most-significant in the low n bytes
  // --------------------------------------------------------------------------
  typedef struct {
    logic [159:0] bytes;
    int           n;
    logic         exp_valid;
    logic         exp_err;
    logic [1:0]   exp_code;
    logic [7:0]   exp_cmd;
    logic [7:0]   exp_len;
    logic [7:0]   addr_a;
    logic [7:0]   exp_a;
    logic [7:0]   addr_b;
    logic [7:0]   exp_b;
  } vec_t;

  vec_t vecs [7];

  function automatic vec_t mk(input logic [159:0] b, input int n, input logic v,
                              input logic e, input logic [1:0] c,
                              input logic [7:0] cmd, input logic [7:0] len,
                              input logic [7:0] aa, input logic [7:0] ea,
                              input logic [7:0] ab, input logic [7:0] eb);
    vec_t r;
    r.bytes = b; r.n = n; r.exp_valid = v; r.exp_err = e; r.exp_code = c;
    r.exp_cmd = cmd; r.exp_len = len;
    r.addr_a = aa; r.exp_a = ea; r.addr_b = ab; r.exp_b = eb;
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input int i);
    int e0;
    e0 = err_pulses;
    for (int k = 0; k < v.n; k++) begin
      send(v.bytes[8*(v.n-1-k) +: 8]);
    end
    check($sformatf("v%0d_valid", i), 32'(o_Cmd_Valid), 32'(v.exp_valid));
    check($sformatf("v%0d_err", i), 32'(o_Err), 32'(v.exp_err));
    if (v.exp_err) begin
      check($sformatf("v%0d_code", i), 32'(o_Err_Code), 32'(v.exp_code));
    end
    if (v.exp_valid) begin
      check($sformatf("v%0d_cmd", i), 32'(o_Cmd), 32'(v.exp_cmd));
      check($sformatf("v%0d_len", i), 32'(o_Len), 32'(v.exp_len));
      i_Rd_Addr = v.addr_a;
      #1;
      check($sformatf("v%0d_rd_a", i), 32'(o_Rd_Data), 32'(v.exp_a));
      i_Rd_Addr = v.addr_b;
      #1;
      check($sformatf("v%0d_rd_b", i), 32'(o_Rd_Data), 32'(v.exp_b));
    end
    tick();
    check($sformatf("v%0d_err_1cyc", i), 32'(o_Err), 32'd0);
    check($sformatf("v%0d_err_count", i), 32'(err_pulses - e0), 32'(v.exp_err));
    if (v.exp_valid) begin
      check($sformatf("v%0d_valid_held", i), 32'(o_Cmd_Valid), 32'd1);
      ack();
      check($sformatf("v%0d_valid_drop", i), 32'(o_Cmd_Valid), 32'd0);
    end
    check($sformatf("v%0d_idle", i), 32'(o_Dbg_State), 32'(ST_IDLE));
  endtask

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    int e0;
    int o0;
    int waited;
    logic found;

    // Good frame: 05^02^11^22 = 34
    vecs[0] = mk(160'({8'hAA, 8'h05, 8'h02, 8'h11, 8'h22, 8'h34}), 6,
                 1'b1, 1'b0, 2'b00, 8'h05, 8'h02, 8'd0, 8'h11, 8'd1, 8'h22);
    // Bad checksum
    vecs[1] = mk(160'({8'hAA, 8'h05, 8'h02, 8'h11, 8'h22, 8'h35}), 6,
                 1'b0, 1'b1, 2'b10, 8'h00, 8'h00, 8'd0, 8'h00, 8'd0, 8'h00);
    // Zero-length frame; buffer keeps the earlier payload
    vecs[2] = mk(160'({8'hAA, 8'h07, 8'h00, 8'h07}), 4,
                 1'b1, 1'b0, 2'b00, 8'h07, 8'h00, 8'd0, 8'h11, 8'd1, 8'h22);
    // Length 17 > MAX_LEN
    vecs[3] = mk(160'({8'hAA, 8'h05, 8'h11}), 3,
                 1'b0, 1'b1, 2'b01, 8'h00, 8'h00, 8'd0, 8'h00, 8'd0, 8'h00);
    // Noise before SYNC, SYNC value inside payload: 09^03^AA^01^02 = A3
    vecs[4] = mk(160'({8'h3C, 8'hAA, 8'h09, 8'h03, 8'hAA, 8'h01, 8'h02, 8'hA3}), 8,
                 1'b1, 1'b0, 2'b00, 8'h09, 8'h03, 8'd0, 8'hAA, 8'd1, 8'h01);
    // One-byte payload, buf[1] untouched: 0F^01^FF = F1
    vecs[5] = mk(160'({8'hAA, 8'h0F, 8'h01, 8'hFF, 8'hF1}), 5,
                 1'b1, 1'b0, 2'b00, 8'h0F, 8'h01, 8'd0, 8'hFF, 8'd1, 8'h01);
    // Length exactly MAX_LEN, payload 00..0F (XOR 00): 01^10 = 11
    vecs[6] = mk(160'({8'hAA, 8'h01, 8'h10, 128'h000102030405060708090A0B0C0D0E0F, 8'h11}), 20,
                 1'b1, 1'b0, 2'b00, 8'h01, 8'h10, 8'd0, 8'h00, 8'd15, 8'h0F);

    // Reset state
    repeat (3) tick();
    check("rst_valid", 32'(o_Cmd_Valid), 32'd0);
    check("rst_cmd", 32'(o_Cmd), 32'd0);
    check("rst_len", 32'(o_Len), 32'd0);
    check("rst_err", 32'(o_Err), 32'd0);
    check("rst_code", 32'(o_Err_Code), 32'd0);
    check("rst_ovr", 32'(o_Overrun), 32'd0);
    check("rst_rd0", 32'(o_Rd_Data), 32'd0);
    check("rst_state", 32'(o_Dbg_State), 32'(ST_IDLE));
    i_Reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], i);
    end

    // Out-of-range reads return 0; last in-range entry holds 0F
    i_Rd_Addr = 8'd15;
    #1;
    check("rd_addr15", 32'(o_Rd_Data), 32'h0F);
    i_Rd_Addr = 8'd16;
    #1;
    check("rd_addr16", 32'(o_Rd_Data), 32'h00);
    i_Rd_Addr = 8'd255;
    #1;
    check("rd_addr255", 32'(o_Rd_Data), 32'h00);
    i_Rd_Addr = 8'd0;

    // Timeout: error exactly TIMEOUT_CLKS edges after the CMD byte
    send(8'hAA);
    send(8'h05);
    waited = 0;
    found  = 1'b0;
    for (int k = 1; k <= TIMEOUT_CLKS + 10; k++) begin
      tick();
      if (o_Err) begin
        waited = k;
        found  = 1'b1;
        break;
      end
    end
    check("timeout_seen", 32'(found), 32'd1);
    check("timeout_cycles", 32'(waited), 32'(TIMEOUT_CLKS));
    check("timeout_code", 32'(o_Err_Code), 32'd3);

    // Noise in idle: no response
    tick();
    e0 = err_pulses;
    send(8'h3C);
    repeat (3) tick();
    check("noise_err", 32'(err_pulses - e0), 32'd0);
    check("noise_state", 32'(o_Dbg_State), 32'(ST_IDLE));
    check("noise_valid", 32'(o_Cmd_Valid), 32'd0);

    // A byte in the last allowed cycle beats the timeout
    e0 = err_pulses;
    send(8'hAA);
    send(8'h05);
    repeat (TIMEOUT_CLKS - 1) tick();
    send(8'h00);
    check("to_edge_err", 32'(o_Err), 32'd0);
    check("to_edge_state", 32'(o_Dbg_State), 32'(ST_CHK));
    send(8'h05);
    check("to_edge_valid", 32'(o_Cmd_Valid), 32'd1);
    check("to_edge_len", 32'(o_Len), 32'h00);
    tick();
    check("to_edge_noerr", 32'(err_pulses - e0), 32'd0);
    ack();

    // Overrun while holding, then DV together with ack
    o0 = ovr_pulses;
    send(8'hAA); send(8'h05); send(8'h02); send(8'h11); send(8'h22); send(8'h34);
    check("ovr_valid", 32'(o_Cmd_Valid), 32'd1);
    send(8'h55);
    check("ovr_pulse", 32'(o_Overrun), 32'd1);
    check("ovr_valid_kept", 32'(o_Cmd_Valid), 32'd1);
    check("ovr_cmd_kept", 32'(o_Cmd), 32'h05);
    check("ovr_len_kept", 32'(o_Len), 32'h02);
    i_Rd_Addr = 8'd1;
    #1;
    check("ovr_buf_kept", 32'(o_Rd_Data), 32'h22);
    i_Rd_Addr = 8'd0;
    check("ovr_state", 32'(o_Dbg_State), 32'(ST_HOLD));
    tick();
    check("ovr_1cyc", 32'(o_Overrun), 32'd0);
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = 8'hAA;
    i_Cmd_Ack = 1'b1;
    tick();
    i_Rx_DV   = 1'b0;
    i_Cmd_Ack = 1'b0;
    check("ovr_ack_pulse", 32'(o_Overrun), 32'd1);
    check("ovr_ack_valid", 32'(o_Cmd_Valid), 32'd0);
    check("ovr_ack_idle", 32'(o_Dbg_State), 32'(ST_IDLE));
    tick();
    check("ovr_count", 32'(ovr_pulses - o0), 32'd2);

    // Asynchronous reset mid-payload
    e0 = err_pulses;
    send(8'hAA); send(8'h09); send(8'h02); send(8'h77);
    #2;
    i_Reset = 1'b1;
    #1;
    check("arst_valid", 32'(o_Cmd_Valid), 32'd0);
    check("arst_cmd", 32'(o_Cmd), 32'd0);
    check("arst_len", 32'(o_Len), 32'd0);
    check("arst_code", 32'(o_Err_Code), 32'd0);
    check("arst_rd0", 32'(o_Rd_Data), 32'd0);
    check("arst_state", 32'(o_Dbg_State), 32'(ST_IDLE));
    @(negedge i_Clock);
    i_Reset = 1'b0;
    tick();
    check("arst_noerr", 32'(err_pulses - e0), 32'd0);
    send(8'hAA); send(8'h05); send(8'h02); send(8'h11); send(8'h22); send(8'h34);
    check("arst_next_valid", 32'(o_Cmd_Valid), 32'd1);
    check("arst_next_cmd", 32'(o_Cmd), 32'h05);
    i_Rd_Addr = 8'd1;
    #1;
    check("arst_next_buf1", 32'(o_Rd_Data), 32'h22);
    ack();
    check("arst_next_drop", 32'(o_Cmd_Valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
